// File: rtl/iir8_pkg.sv
// Shared types and address decode for the iir8 coefficient sequencer.
package iir8_pkg;

  localparam int DEF_COEFF_BITS = 18;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SWAP  = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  // Address layout is {stage, sel}; sel 0 selects b1, 1 selects b2.
  function automatic int unsigned stage_of(input int unsigned addr);
    return addr >> 1;
  endfunction

  function automatic logic sel_of(input int unsigned addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/iir8_coeff_sequencer_if.sv
// Host-side shadow write and commit bus of the iir8 coefficient sequencer.
interface iir8_coeff_sequencer_if #(
  parameter int AW         = 3,
  parameter int COEFF_BITS = 18
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [AW-1:0]         wr_addr;
  logic [COEFF_BITS-1:0] wr_data;
  logic                  commit;

  modport master (output wr_valid, wr_addr, wr_data, commit, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, commit, output wr_ready);
endinterface

// File: rtl/iir8_coeff_bank.sv
// NSTAGES x {b1, b2} coefficient register bank: single-word write port plus bulk load.
module iir8_coeff_bank #(
  parameter int NSTAGES    = 4,
  parameter int COEFF_BITS = 18
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          we_i,
  input  int unsigned                   stage_i,
  input  logic                          sel_i,
  input  logic [COEFF_BITS-1:0]         data_i,
  input  logic                          load_i,
  input  logic [NSTAGES*COEFF_BITS-1:0] load1_i,
  input  logic [NSTAGES*COEFF_BITS-1:0] load2_i,
  output logic [NSTAGES*COEFF_BITS-1:0] coeff1_o,
  output logic [NSTAGES*COEFF_BITS-1:0] coeff2_o
);
  logic [NSTAGES*COEFF_BITS-1:0] c1_q, c2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c1_q <= '0;
      c2_q <= '0;
    end else if (load_i) begin
      c1_q <= load1_i;
      c2_q <= load2_i;
    end else if (we_i) begin
      if (sel_i) c2_q[stage_i*COEFF_BITS +: COEFF_BITS] <= data_i;
      else       c1_q[stage_i*COEFF_BITS +: COEFF_BITS] <= data_i;
    end
  end

  assign coeff1_o = c1_q;
  assign coeff2_o = c2_q;
endmodule

// File: rtl/iir8_coeff_sequencer.sv
// Shadow/active coefficient banks with swap-and-flush sequencing of the DSP P-register reset.
// Optional readback port enabled by defining IIR8_COEFF_READBACK_EN.
//
// state | meaning
// RUN   | DSPs running on the active bank, commits start a swap
// SWAP  | one cycle; active bank loads from shadow on the closing edge
// FLUSH | dsp_rst held FLUSH_CYCLES cycles to drain the chain
module iir8_coeff_sequencer
  import iir8_pkg::*;
#(
  parameter int NSTAGES      = 4,
  parameter int COEFF_BITS   = DEF_COEFF_BITS,
  parameter int FLUSH_CYCLES = 8,
  localparam int AW          = $clog2(2*NSTAGES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  iir8_coeff_sequencer_if.slave         bus,
  output logic                          commit_busy_o,
  output logic                          wr_err_o,
  output logic [NSTAGES*COEFF_BITS-1:0] coeff1_out_o,
  output logic [NSTAGES*COEFF_BITS-1:0] coeff2_out_o,
  output logic                          dsp_rst_o,
  output logic                          running_o,
  output logic [15:0]                   update_count_o
`ifdef IIR8_COEFF_READBACK_EN
  ,
  input  logic [AW-1:0]                 rd_addr_i,
  input  logic                          rd_bank_i,
  output logic [COEFF_BITS-1:0]         rd_data_o
`endif
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned NADDR = 2 * NSTAGES;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          after_swap_q, after_swap_d;
  logic [15:0]   update_count_q, update_count_d;
  logic          wr_err_q, wr_ready_q, dsp_rst_q, running_q, commit_busy_q;
  logic          load, wr_fire, addr_ok;

  logic [NSTAGES*COEFF_BITS-1:0] sh1, sh2, act1, act2;

  assign wr_fire = bus.wr_valid && wr_ready_q;
  assign addr_ok = 32'(bus.wr_addr) < NADDR;

  iir8_coeff_bank #(.NSTAGES(NSTAGES), .COEFF_BITS(COEFF_BITS)) u_shadow (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_fire && addr_ok),
    .stage_i (stage_of(32'(bus.wr_addr))),
    .sel_i   (sel_of(32'(bus.wr_addr))),
    .data_i  (bus.wr_data),
    .load_i  (1'b0),
    .load1_i ('0),
    .load2_i ('0),
    .coeff1_o(sh1),
    .coeff2_o(sh2)
  );

  iir8_coeff_bank #(.NSTAGES(NSTAGES), .COEFF_BITS(COEFF_BITS)) u_active (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (1'b0),
    .stage_i (0),
    .sel_i   (1'b0),
    .data_i  ('0),
    .load_i  (load),
    .load1_i (sh1),
    .load2_i (sh2),
    .coeff1_o(act1),
    .coeff2_o(act2)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    after_swap_d   = after_swap_q;
    update_count_d = update_count_q;
    load           = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.commit) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        load         = 1'b1;
        state_d      = ST_FLUSH;
        cnt_d        = CNT_INIT;
        after_swap_d = 1'b1;
        if (bus.commit) pending_d = 1'b1;
      end
      ST_FLUSH: begin
        if (bus.commit) pending_d = 1'b1;
        if (cnt_q == '0) begin
          // The power-on flush did not follow a swap and is not counted.
          if (after_swap_q) update_count_d = update_count_q + 16'd1;
          after_swap_d = 1'b0;
          if (pending_q || bus.commit) begin
            state_d   = ST_SWAP;
            pending_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_FLUSH;
      cnt_q          <= CNT_INIT;
      pending_q      <= 1'b0;
      after_swap_q   <= 1'b0;
      update_count_q <= '0;
      wr_err_q       <= 1'b0;
      wr_ready_q     <= 1'b1;
      dsp_rst_q      <= 1'b1;
      running_q      <= 1'b0;
      commit_busy_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      after_swap_q   <= after_swap_d;
      update_count_q <= update_count_d;
      wr_err_q       <= wr_err_q | (wr_fire && !addr_ok);
      wr_ready_q     <= (state_d != ST_SWAP);
      dsp_rst_q      <= (state_d != ST_RUN);
      running_q      <= (state_d == ST_RUN);
      commit_busy_q  <= (state_d != ST_RUN) || pending_d;
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign commit_busy_o  = commit_busy_q;
  assign wr_err_o       = wr_err_q;
  assign coeff1_out_o   = act1;
  assign coeff2_out_o   = act2;
  assign dsp_rst_o      = dsp_rst_q;
  assign running_o      = running_q;
  assign update_count_o = update_count_q;

`ifdef IIR8_COEFF_READBACK_EN
  logic [COEFF_BITS-1:0]         rd_data_q, rd_data_d;
  logic [NSTAGES*COEFF_BITS-1:0] rd_src;
  int unsigned                   rd_stage;

  always_comb begin
    rd_data_d = '0;
    rd_stage  = stage_of(32'(rd_addr_i));
    if (rd_bank_i) rd_src = sel_of(32'(rd_addr_i)) ? act2 : act1;
    else           rd_src = sel_of(32'(rd_addr_i)) ? sh2 : sh1;
    if (32'(rd_addr_i) < NADDR) rd_data_d = rd_src[rd_stage*COEFF_BITS +: COEFF_BITS];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;
`endif
endmodule

// File: tb/tb_iir8_coeff_sequencer.sv
// Directed bench for iir8_coeff_sequencer; three stages so that address 2*NSTAGES is reachable.
module tb_iir8_coeff_sequencer;
  localparam int NS = 3;
  localparam int CB = 18;
  localparam int FC = 8;
  localparam int AW = $clog2(2*NS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic              commit_busy, wr_err, dsp_rst, running;
  logic [NS*CB-1:0]  coeff1, coeff2;
  logic [15:0]       update_count;
  int errors = 0;
  int checks = 0;
  int n;
  bit early_idle;

  always #5 clk = ~clk;

  iir8_coeff_sequencer_if #(.AW(AW), .COEFF_BITS(CB)) bus ();

`ifdef IIR8_COEFF_READBACK_EN
  logic [AW-1:0] rd_addr = '0;
  logic          rd_bank = 1'b0;
  logic [CB-1:0] rd_data;
`endif

  iir8_coeff_sequencer #(.NSTAGES(NS), .COEFF_BITS(CB), .FLUSH_CYCLES(FC)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .commit_busy_o (commit_busy),
    .wr_err_o      (wr_err),
    .coeff1_out_o  (coeff1),
    .coeff2_out_o  (coeff2),
    .dsp_rst_o     (dsp_rst),
    .running_o     (running),
    .update_count_o(update_count)
`ifdef IIR8_COEFF_READBACK_EN
    ,
    .rd_addr_i     (rd_addr),
    .rd_bank_i     (rd_bank),
    .rd_data_o     (rd_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts sampled cycles with dsp_rst high until it drops (bounded).
  task automatic count_flush(output int cnt);
    cnt = 0;
    while (dsp_rst && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.commit   = 1'b0;

    // 1: reset values and release
    repeat (3) tick();
    chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_busy", 64'(commit_busy), 64'd1);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_coeff1", 64'(coeff1), 64'd0);
    chk("rst_wr_err", 64'(wr_err), 64'd0);
    rst = 1'b0;
    count_flush(n);
    chk("rel_flush_len", 64'(n), 64'd8);
    chk("rel_running", 64'(running), 64'd1);
    chk("rel_busy", 64'(commit_busy), 64'd0);
    chk("rel_count", 64'(update_count), 64'd0);
    chk("rel_coeff2", 64'(coeff2), 64'd0);
`ifdef IIR8_COEFF_READBACK_EN
    tick();
    chk("rd_reset_shadow", 64'(rd_data), 64'd0);
`endif

    // 2: two writes then commit
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 18'h04000; tick();
    bus.wr_addr = 3'd3; bus.wr_data = 18'h3C000; tick();
    bus.wr_valid = 1'b0; bus.commit = 1'b1; tick();
    bus.commit = 1'b0;
    chk("swap_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("swap_coeff_old", 64'(coeff1[17:0]), 64'd0);
    chk("swap_busy", 64'(commit_busy), 64'd1);
    tick();
    chk("t2_coeff1_s0", 64'(coeff1[17:0]), 64'h04000);
    chk("t2_coeff2_s1", 64'(coeff2[35:18]), 64'h3C000);
    chk("t2_flush_wr_ready", 64'(bus.wr_ready), 64'd1);
    count_flush(n);
    chk("t2_dsp_rst_len", 64'(n + 1), 64'd9);
    chk("t2_count", 64'(update_count), 64'd1);
    chk("t2_running", 64'(running), 64'd1);
`ifdef IIR8_COEFF_READBACK_EN
    rd_bank = 1'b1; rd_addr = 3'd0; tick();
    chk("rd_active_a0", 64'(rd_data), 64'h04000);
    rd_bank = 1'b0;
`endif

    // 3: write coincident with commit, then a write during FLUSH
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 18'h00123; bus.commit = 1'b1; tick();
    bus.wr_valid = 1'b0; bus.commit = 1'b0; tick();
    chk("t3_same_cycle", 64'(coeff2[17:0]), 64'h00123);
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 18'h00456; tick();
    bus.wr_valid = 1'b0;
    chk("t3_flush_write", 64'(coeff2[17:0]), 64'h00123);
    count_flush(n);
    chk("t3_after_flush", 64'(coeff2[17:0]), 64'h00123);
    chk("t3_count", 64'(update_count), 64'd2);

    // 4: commits during SWAP/FLUSH merge into one extra back-to-back swap
    bus.commit = 1'b1; tick();
    bus.commit = 1'b0;
    n = 0;
    early_idle = 1'b0;
    while (!running && n < 40) begin
      n++;
      bus.commit = (n == 3 || n == 5 || n == 7);
      if (!commit_busy) early_idle = 1'b1;
      tick();
      if (n == 1) chk("t4_new_coeff", 64'(coeff2[17:0]), 64'h00456);
    end
    bus.commit = 1'b0;
    chk("t4_busy_cycles", 64'(n), 64'd18);
    chk("t4_busy_held", 64'(early_idle), 64'd0);
    chk("t4_count", 64'(update_count), 64'd4);
    chk("t4_busy_low", 64'(commit_busy), 64'd0);
    tick();
    chk("t4_no_third_swap", 64'(dsp_rst), 64'd0);

    // 5: out-of-range writes are accepted and dropped
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 18'h1FFFF; tick();
    chk("t5_ready", 64'(bus.wr_ready), 64'd1);
    bus.wr_addr = 3'd7; tick();
    bus.wr_valid = 1'b0;
    chk("t5_wr_err", 64'(wr_err), 64'd1);
    bus.commit = 1'b1; tick();
    bus.commit = 1'b0;
    tick();
    count_flush(n);
    chk("t5_coeff1_all", 64'(coeff1), {10'd0, 18'd0, 18'd0, 18'h04000});
    chk("t5_coeff2_all", 64'(coeff2), {10'd0, 18'd0, 18'h3C000, 18'h00456});
    chk("t5_err_sticky", 64'(wr_err), 64'd1);
    chk("t5_count", 64'(update_count), 64'd5);

    // 6: reset on flush cycle 3 with a pending commit
    bus.commit = 1'b1; tick();
    bus.commit = 1'b0; tick();
    bus.commit = 1'b1; tick();
    bus.commit = 1'b0; tick();
    chk("t6_pending_busy", 64'(commit_busy), 64'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("t6_rst_count", 64'(update_count), 64'd0);
    chk("t6_rst_coeff1", 64'(coeff1), 64'd0);
    chk("t6_rst_coeff2", 64'(coeff2), 64'd0);
    chk("t6_rst_wr_err", 64'(wr_err), 64'd0);
    chk("t6_rst_dsp", 64'(dsp_rst), 64'd1);
    chk("t6_rst_running", 64'(running), 64'd0);
`ifdef IIR8_COEFF_READBACK_EN
    rd_bank = 1'b0; rd_addr = 3'd0; tick();
    chk("t6_rd_shadow", 64'(rd_data), 64'd0);
    count_flush(n);
    chk("t6_flush_len", 64'(n + 1), 64'd8);
`else
    count_flush(n);
    chk("t6_flush_len", 64'(n), 64'd8);
`endif
    tick();
    chk("t6_pending_lost", 64'(running), 64'd1);
    chk("t6_count_after", 64'(update_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
